pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the CPU datapath, replacing the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a generic data word plus a control vector under a valid/ready handshake. A 2-entry skid buffer decouples back-pressure from upstream timing. It also provides internal hold on memory stall (no external feedback of held values), flush-to-bubble, and a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 107: width of the data payload (operands, immediate, register indices)
- CTRL_W, 8: width of the control vector (RegWrite, MemWrite, MemRead, ALUSrc, MemtoReg, ALUCtrl); all-zero is a bubble
- CNT_W, 16: width of the stall-cycle counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  upstream has a word
- in_ready_o  out  1  stage can accept
- in_data_i  in  DATA_W  upstream payload
- in_ctrl_i  in  CTRL_W  upstream control vector
- stall_i  in  1  global hold (memory stall); freezes the stage
- flush_i  in  1  discard all held words
- out_valid_o  out  1  stage presents a word
- out_ready_i  in  1  downstream can accept
- out_data_o  out  DATA_W  presented payload
- out_ctrl_o  out  CTRL_W  presented control; forced to 0 when out_valid_o is 0
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles

## Operation
- Storage: main slot (drives outputs) and skid slot, each with a valid bit.
- States: EMPTY (none valid), FULL (main valid), SKID (both valid).
- in_ready_o = !skid_valid && !stall_i && !flush_i. This signal is combinational from stall_i/flush_i only and never from out_ready_i.
- out_valid_o = main_valid && !stall_i.
- Input fire: in_valid_i && in_ready_o. Output fire: out_valid_o && out_ready_i.
- Transitions (stall_i=0, flush_i=0):
  - EMPTY: in fire -> FULL (main <= in).
  - FULL: in fire and out fire -> FULL (main <= in). In fire only -> SKID (skid <= in). Out fire only -> EMPTY.
  - SKID: out fire -> FULL (main <= skid). Otherwise hold.
- Words are delivered in order; no word is lost or duplicated.
- stall_i=1: no fire on either side; all slots and data hold their values.
- flush_i=1: at the next edge both valid bits clear and the state becomes EMPTY. The input is not accepted that cycle. Flush beats stall.
- Data registers are not cleared on flush. Only valid bits clear, and out_ctrl_o gating guarantees a bubble.
- stall_cnt_o increments when stall_i=1 && main_valid=1. It saturates at 2^CNT_W-1 and is cleared only by reset.

## Timing
- Reset (rst_i low, asynchronous): state EMPTY, both valid bits 0, data and ctrl registers 0, stall_cnt_o=0. Outputs after reset: out_valid_o=0, out_ctrl_o=0, out_data_o=0, in_ready_o=!stall_i && !flush_i.
- Reset release is sampled by the flop; the first fire can occur at the first rising edge after release.
- Latency: a word accepted at edge N is presented (out_valid_o=1) from edge N until the next edge after it fires. Throughput is 1 word/cycle with out_ready_i held high.
- in_ready_o falls at the edge that fills the skid slot. It rises at the edge where the skid word moves to main.
- Reset mid-operation drops all held words immediately, without waiting for a clock edge.

## Structure
- Shared package pipe_pkg holds:
  - the state enum typedef pipe_state_t {EMPTY, FULL, SKID}
  - the bubble constant CTRL_BUBBLE = '0
  - localparams for the default control-field bit positions, reused by decode and forwarding.
- One sub-module, sat_counter (parameter W, ports clk_i, rst_i, inc_i, cnt_o), implements the stall counter.

## Test plan
- Reset mid-stream: hold 2 words, drive rst_i low between edges -> out_valid_o=0, out_data_o=0 and stall_cnt_o=0 immediately.
- Streaming: out_ready_i=1, send data 1..10 back to back -> output 1..10 in order, one per cycle, in_ready_o constantly 1.
- Back-pressure: out_ready_i=0, send A, B, C -> A and B accepted, in_ready_o=0 after B, C held upstream. Then raise out_ready_i -> A, B, C delivered in order.
- Stall: in FULL with word X, stall_i=1 for 5 cycles -> out_valid_o=0, in_ready_o=0, X retained, stall_cnt_o=5. On release, X delivered.
- Flush: in SKID state, flush_i=1 with in_valid_i=1 and stall_i=1 -> next cycle EMPTY, input not taken, out_ctrl_o=0.
- Saturation: CNT_W=3, stall_i=1 with a valid word for 10 cycles -> stall_cnt_o stops at 7.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and control-field layout for pipeline stage registers
package pipe_pkg;

  // Occupancy of a stage: nothing held, main slot only, main and skid slots
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  // A control vector of all zeros is a bubble: no architectural side effects
  localparam logic CTRL_BUBBLE = '0;

  // Default control-vector field positions, shared by decode and forwarding
  localparam int unsigned CTRL_REGWRITE_BIT = 0;
  localparam int unsigned CTRL_MEMWRITE_BIT = 1;
  localparam int unsigned CTRL_MEMREAD_BIT  = 2;
  localparam int unsigned CTRL_ALUSRC_BIT   = 3;
  localparam int unsigned CTRL_MEMTOREG_BIT = 4;
  localparam int unsigned CTRL_ALUCTRL_LSB  = 5;
  localparam int unsigned CTRL_ALUCTRL_W    = 3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, cleared only by reset
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Count up on request and stick at the all-ones maximum
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with skid slot, stall hold, flush and stall counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 107,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  pipe_state_t       state_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;

  assign main_valid = (state_q == FULL) || (state_q == SKID);
  assign skid_valid = (state_q == SKID);

  // Ready depends only on local occupancy and the global hold/flush, never on out_ready_i
  assign in_ready_o  = !skid_valid && !stall_i && !flush_i;
  assign out_valid_o = main_valid && !stall_i;

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;

  // Payload is presented straight from the main slot; control is gated to a bubble when not valid
  assign out_data_o = main_data_q;
  assign out_ctrl_o = out_valid_o ? main_ctrl_q : {CTRL_W{CTRL_BUBBLE}};

  // Occupancy FSM and slot data; flush only drops valid state, payload registers keep their contents
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_q <= in_data_i;
            main_ctrl_q <= in_ctrl_i;
            state_q     <= FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_data_q <= in_data_i;
            main_ctrl_q <= in_ctrl_i;
          end else if (in_fire) begin
            skid_data_q <= in_data_i;
            skid_ctrl_q <= in_ctrl_i;
            state_q     <= SKID;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
            state_q     <= FULL;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_i && main_valid),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 107;
  localparam int unsigned CTRL_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              stall;
  logic              flush;
  logic              out_ready;

  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [15:0]       stall_cnt;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [DATA_W-1:0] s_out_data;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [2:0]        s_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl), .stall_i(stall), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ctrl_o(out_ctrl), .stall_cnt_o(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(3)) dut_sat (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl), .stall_i(stall), .flush_i(flush),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_data_o(s_out_data),
    .out_ctrl_o(s_out_ctrl), .stall_cnt_o(s_stall_cnt)
  );

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c);
    in_valid = v;
    in_data  = DATA_W'(d);
    in_ctrl  = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive(1'b0, 0, 0); stall = 0; flush = 0; out_ready = 0;
    #3;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    n_tests++; if (out_ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_out_ctrl got %0h exp 0", out_ctrl); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    stall = 1'b1; #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_stall got %0b exp 0", in_ready); end
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, i, 8'(i));
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %0b exp 1", i, in_ready); end
      step();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_out_valid[%0d] got %0b exp 1", i, out_valid); end
      n_tests++; if (out_data !== DATA_W'(i)) begin n_fail++; $display("FAIL stream_out_data[%0d] got %0h exp %0h", i, out_data, i); end
      n_tests++; if (out_ctrl !== 8'(i)) begin n_fail++; $display("FAIL stream_out_ctrl[%0d] got %0h exp %0h", i, out_ctrl, i); end
    end
    drive(1'b0, 0, 0);
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 8'h11);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a got %0b exp 1", in_ready); end
    step();
    drive(1'b1, 32'hB, 8'h22);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_b got %0b exp 1", in_ready); end
    step();
    drive(1'b1, 32'hC, 8'h33);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after_b got %0b exp 0", in_ready); end
    n_tests++; if (out_data !== DATA_W'(32'hA)) begin n_fail++; $display("FAIL bp_head_a got %0h exp a", out_data); end
    step();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_hold got %0b exp 0", in_ready); end
    n_tests++; if (out_ctrl !== 8'h11) begin n_fail++; $display("FAIL bp_hold_ctrl got %0h exp 11", out_ctrl); end
    out_ready = 1'b1;
    step();
    n_tests++; if (out_data !== DATA_W'(32'hB)) begin n_fail++; $display("FAIL bp_out_b got %0h exp b", out_data); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got %0b exp 1", in_ready); end
    step();
    drive(1'b0, 0, 0);
    n_tests++; if (out_data !== DATA_W'(32'hC)) begin n_fail++; $display("FAIL bp_out_c got %0h exp c", out_data); end
    n_tests++; if (out_ctrl !== 8'h33) begin n_fail++; $display("FAIL bp_out_c_ctrl got %0h exp 33", out_ctrl); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0;
    drive(1'b1, 32'h55, 8'h05); step();
    drive(1'b1, 32'h66, 8'h06); step();
    drive(1'b0, 0, 0);
    stall = 1'b1; step(); step();
    stall = 1'b0;
    n_tests++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL rst_mid_pre_cnt got %0d exp 2", stall_cnt); end
    n_tests++; if (out_data !== DATA_W'(32'h55)) begin n_fail++; $display("FAIL rst_mid_pre_data got %0h exp 55", out_data); end
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %0b exp 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_mid_data got %0h exp 0", out_data); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_cnt got %0d exp 0", stall_cnt); end
    n_tests++; if (s_stall_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_mid_sat_cnt got %0d exp 0", s_stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after got %0b exp 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 32'h77, 8'h0F); step();
    drive(1'b1, 32'h88, 8'h10);
    stall = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_out_valid got %0b exp 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %0b exp 0", in_ready); end
    n_tests++; if (out_ctrl !== 8'h00) begin n_fail++; $display("FAIL stall_out_ctrl got %0h exp 0", out_ctrl); end
    for (int i = 0; i < 5; i++) step();
    n_tests++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt got %0d exp 5", stall_cnt); end
    stall = 1'b0;
    drive(1'b0, 0, 0);
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid got %0b exp 1", out_valid); end
    n_tests++; if (out_data !== DATA_W'(32'h77)) begin n_fail++; $display("FAIL stall_retained got %0h exp 77", out_data); end
    out_ready = 1'b1;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_delivered got %0b exp 0", out_valid); end
    n_tests++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt_hold got %0d exp 5", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h91, 8'h21); step();
    drive(1'b1, 32'h92, 8'h22); step();
    drive(1'b1, 32'h93, 8'h23);
    stall = 1'b1;
    flush = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %0b exp 0", in_ready); end
    step();
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 0, 0);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %0b exp 0", out_valid); end
    n_tests++; if (out_ctrl !== 8'h00) begin n_fail++; $display("FAIL flush_out_ctrl got %0h exp 0", out_ctrl); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_ready got %0b exp 1", in_ready); end
    n_tests++; if (out_data !== DATA_W'(32'h91)) begin n_fail++; $display("FAIL flush_data_kept got %0h exp 91", out_data); end
    out_ready = 1'b1;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_take got %0b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'hEE, 8'h01); step();
    drive(1'b0, 0, 0);
    stall = 1'b1;
    for (int i = 0; i < 10; i++) step();
    stall = 1'b0;
    n_tests++; if (s_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_cnt got %0d exp 7", s_stall_cnt); end
    n_tests++; if (stall_cnt !== 16'd10) begin n_fail++; $display("FAIL wide_cnt got %0d exp 10", stall_cnt); end
    n_tests++; if (s_out_data !== DATA_W'(32'hEE)) begin n_fail++; $display("FAIL sat_data got %0h exp ee", s_out_data); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_reset_mid_stream();
    test_stall();
    test_flush();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
